lnext_bus_sched: RTL

//  Sequences the single next-level (L_NEXT) memory port between the instruction and data caches.

---
 rtl/lnext_bus_sched_pkg.sv | 33 +++
 rtl/lnext_bus_sched_if.sv | 29 ++
 rtl/lnext_bus_sched_rr_arb2.sv | 20 ++
 rtl/lnext_bus_sched.sv | 114 +++++++++++
 4 files changed

// File: rtl/lnext_bus_sched_pkg.sv
// Shared types for the L_NEXT bus scheduler: command encoding, FSM states,
// requester identifiers and a request-validity helper.
package lnext_pkg;

    localparam logic [1:0] ENC_NONE  = 2'b00;
    localparam logic [1:0] ENC_READ  = 2'b01;
    localparam logic [1:0] ENC_WRITE = 2'b10;
    localparam logic [1:0] ENC_RWIM  = 2'b11;

    typedef enum logic [1:0] {
        CMD_NONE  = ENC_NONE,
        CMD_READ  = ENC_READ,
        CMD_WRITE = ENC_WRITE,
        CMD_RWIM  = ENC_RWIM
    } lnext_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } sched_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // A request counts only when it carries a real command.
    function automatic logic cmd_valid(input logic req, input logic [1:0] cmd);
        return req && (cmd != ENC_NONE);
    endfunction

endpackage

// File: rtl/lnext_bus_sched_if.sv
// Requester and L_NEXT signal bundle for lnext_bus_sched.
// master: the scheduler side; slave: the caches and L_NEXT model.
interface lnext_bus_sched_if #(
    parameter int unsigned ADDR_W = 26
);
    logic              i_req;
    logic [1:0]        i_cmd;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              d_req;
    logic [1:0]        d_cmd;
    logic [ADDR_W-1:0] d_addr;
    logic              d_ack;
    logic [ADDR_W-1:0] add_out;
    logic [1:0]        cmd_out;
    logic              lnext_ready;
    logic              err;
    logic              busy;

    modport master (
        input  i_req, i_cmd, i_addr, d_req, d_cmd, d_addr, lnext_ready,
        output i_ack, d_ack, add_out, cmd_out, err, busy
    );

    modport slave (
        output i_req, i_cmd, i_addr, d_req, d_cmd, d_addr, lnext_ready,
        input  i_ack, d_ack, add_out, cmd_out, err, busy
    );
endinterface

// File: rtl/lnext_bus_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant; the caller owns rr_last.
module rr_arb2
    import lnext_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    rr_last,
    output logic       gnt_any,
    output req_id_t    gnt_id
);
    // On contention the side that did not win last time is granted.
    always_comb begin
        gnt_any = |valid;
        gnt_id  = REQ_I;
        if (valid == 2'b11) begin
            gnt_id = (rr_last == REQ_I) ? REQ_D : REQ_I;
        end else if (valid[1]) begin
            gnt_id = REQ_D;
        end
    end
endmodule

// File: rtl/lnext_bus_sched.sv
// L_NEXT port scheduler between icache and dcache with per-command watchdog.
// Optional transaction/timeout counters are built when LNEXT_STATS_EN is defined.
module lnext_bus_sched
    import lnext_pkg::*;
#(
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    lnext_bus_sched_if.master bus
`ifdef LNEXT_STATS_EN
    ,
    output logic [15:0]      stat_i_cnt,
    output logic [15:0]      stat_d_cnt,
    output logic [15:0]      stat_to_cnt
`endif
);
    sched_state_t      state, state_nxt;
    req_id_t           rr_last;
    req_id_t           gnt_id;
    logic              gnt_any;
    logic [1:0]        valid;
    logic [ADDR_W-1:0] addr_q;
    lnext_cmd_t        cmd_q;
    logic [WAIT_W-1:0] wd;
    logic              timed_out;
    logic              wd_expired;

    assign valid[0]   = cmd_valid(bus.i_req, bus.i_cmd);
    assign valid[1]   = cmd_valid(bus.d_req, bus.d_cmd);
    assign wd_expired = (wd == WAIT_W'(MAX_WAIT));

    rr_arb2 u_arb (
        .valid   (valid),
        .rr_last (rr_last),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: grant, wait for completion or watchdog, one-cycle done.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (gnt_any) state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.lnext_ready || wd_expired) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Command/address latch, round-robin pointer and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cmd_q     <= CMD_NONE;
            rr_last   <= REQ_I;
            wd        <= '0;
            timed_out <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        addr_q    <= (gnt_id == REQ_D) ? bus.d_addr : bus.i_addr;
                        cmd_q     <= lnext_cmd_t'((gnt_id == REQ_D) ? bus.d_cmd : bus.i_cmd);
                        rr_last   <= gnt_id;
                        wd        <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (bus.lnext_ready) begin
                        cmd_q <= CMD_NONE;
                    end else if (wd_expired) begin
                        cmd_q     <= CMD_NONE;
                        timed_out <= 1'b1;
                    end else begin
                        wd <= wd + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.add_out = addr_q;
    assign bus.cmd_out = cmd_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.i_ack   = (state == ST_DONE) && (rr_last == REQ_I);
    assign bus.d_ack   = (state == ST_DONE) && (rr_last == REQ_D);
    assign bus.err     = (state == ST_DONE) && timed_out;

`ifdef LNEXT_STATS_EN
    // Saturating completion and timeout counters, updated in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_i_cnt  <= '0;
            stat_d_cnt  <= '0;
            stat_to_cnt <= '0;
        end else if (state == ST_DONE) begin
            if (rr_last == REQ_I && stat_i_cnt != '1) stat_i_cnt <= stat_i_cnt + 16'd1;
            if (rr_last == REQ_D && stat_d_cnt != '1) stat_d_cnt <= stat_d_cnt + 16'd1;
            if (timed_out && stat_to_cnt != '1)       stat_to_cnt <= stat_to_cnt + 16'd1;
        end
    end
`endif
endmodule
